rect_fill_writer: RTL and testbench
===================================

Name: rect_fill_writer

Overview:
- Write-side engine for the VGA frame buffer.
- Accepts rectangle-fill draw commands (origin, size, 12-bit RGB) from the timer/display controller.
- Emits one pixel write per cycle (x, y, colour) toward the video memory, which scans the buffer out to the DAC.
- Coordinates are active-area relative (0..H_ACTIVE-1, 0..V_ACTIVE-1); the memory adds the blanking offsets.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CW, 10, coordinate width in bits
- RGBW, 12, colour width: [3:0] R, [7:4] B, [11:8] G, matching the memory packing

Ports:
- clk  in  1  single pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  CW  rectangle left column
- cmd_y  in  CW  rectangle top row
- cmd_w  in  CW  width in pixels
- cmd_h  in  CW  height in pixels
- cmd_rgb  in  RGBW  fill colour
- wr_valid  out  1  pixel write valid
- wr_ready  in  1  memory accepts write
- wr_x  out  CW  pixel column
- wr_y  out  CW  pixel row
- wr_rgb  out  RGBW  pixel colour
- busy  out  1  engine not IDLE
- done  out  1  one-cycle pulse after last write of a command

Behaviour:
- Reset (async, rst_n low):
  - Outputs: cmd_ready=0, wr_valid=0, wr_x=0, wr_y=0, wr_rgb=0, done=0, busy=0.
  - State: IDLE (or CLEAR with feature); cmd_ready rises the first cycle after reset release in IDLE.
- States:
  - IDLE: cmd_ready=1.
  - FILL: cmd_ready=0, wr_valid=1.
  - DONE: one cycle, done=1, then IDLE.
- Accept: cmd_valid&&cmd_ready at edge N latches the command with clipping:
  - ew = min(cmd_w, H_ACTIVE-cmd_x); eh = min(cmd_h, V_ACTIVE-cmd_y). Compute in CW+1 bits, no wrap.
  - Empty case: cmd_x>=H_ACTIVE, cmd_y>=V_ACTIVE, ew==0 or eh==0 -> DONE directly, no writes, done at N+1.
  - Otherwise FILL; first wr_valid at N+1 with wr_x=cmd_x, wr_y=cmd_y.
- Raster order within FILL: x increments first, then y.
  - Advance only on wr_valid&&wr_ready.
  - Last column: x returns to cmd_x and y increments.
  - Last pixel (x0+ew-1, y0+eh-1) handshaken at edge M -> DONE at M+1, done=1 for that cycle only; cmd_ready=1 at M+2.
- Backpressure: while wr_ready=0, wr_x/wr_y/wr_rgb hold stable and wr_valid stays 1. No pixel is dropped or duplicated.
- Throughput: one pixel per cycle when wr_ready is held high; ew*eh write cycles per command.
- Command handling: cmd_* are ignored outside IDLE. No queuing; the producer holds cmd_valid until accepted.
- Reset mid-FILL: abort immediately, no done pulse, no further writes; the partial rectangle stays in memory.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: RECT_FILL_CLEAR_ON_RESET_EN.
- Defined:
  - Reset state is CLEAR: writes rgb=0 to every pixel (0,0)..(H_ACTIVE-1,V_ACTIVE-1) in raster order under the same handshake.
  - Then one done pulse, then IDLE; busy=1 and cmd_ready=0 throughout.
  - Replaces the simulation-only zeroing loop in the memory.
- Undefined: reset goes straight to IDLE and no clear writes occur.

Decomposition:
- Package rect_fill_pkg:
  - H_ACTIVE/V_ACTIVE defaults.
  - State enum (IDLE, CLEAR, FILL, DONE).
  - RGB field index constants.
- Sub-module raster_walker: x/y counter pair with load (x0,y0,w,h), advance and last output; shared by FILL and CLEAR.

Test Plan:
- Basic fill: cmd (x=10, y=20, w=3, h=2, rgb=0xF00), wr_ready=1 -> exactly 6 writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), all rgb=0xF00; done the cycle after the 6th; cmd_ready 1 cycle later.
- Backpressure: same cmd, wr_ready toggling 1,0,0,1,... -> outputs stable during stalls, same 6 writes in order, no repeats.
- Clipping: cmd (x=638, y=479, w=5, h=4) -> writes only (638,479)(639,479); cmd (x=700, y=0, w=4, h=4) -> zero writes, done at accept+1.
- Zero size: w=0, h=7 -> no wr_valid, single done pulse.
- Reset mid-fill: cmd (0, 0, 100, 100), assert rst_n low after 37 writes -> wr_valid=0 immediately, no done, cmd_ready=1 one cycle after release (no macro).
- With RECT_FILL_CLEAR_ON_RESET_EN: after reset, 307200 writes of rgb=0 covering (0,0)..(639,479), then done, then cmd_ready=1; a cmd_valid presented during CLEAR is not accepted until IDLE.

Source files
------------

// File: rtl/rect_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_pkg
//  Description : Shared constants and the state type for the rectangle-fill
//                write engine of the VGA frame buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_fill_pkg;

    // Default visible raster size (coordinates are active-area relative)
    localparam int c_H_ACTIVE_DEF = 640;
    localparam int c_V_ACTIVE_DEF = 480;

    // Engine states; CLEAR is only entered from reset when the clear option is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Colour field positions, matching the video memory packing
    localparam int c_RGB_R_LSB = 0;
    localparam int c_RGB_R_MSB = 3;
    localparam int c_RGB_B_LSB = 4;
    localparam int c_RGB_B_MSB = 7;
    localparam int c_RGB_G_LSB = 8;
    localparam int c_RGB_G_MSB = 11;

endpackage
`default_nettype wire

// File: rtl/raster_walker.sv
`default_nettype none
// ============================================================================
//  Module      : raster_walker
//  Description : x/y raster counter pair. Loaded with an origin and a
//                (pre-clipped, non-zero) size, it steps x first then y on
//                each advance and flags the final pixel of the rectangle.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_walker #(
    parameter int             CW         = 10,
    parameter logic [CW-1:0]  RST_X_LAST = '0,
    parameter logic [CW-1:0]  RST_Y_LAST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW:0]   w,
    input  logic [CW:0]   h,
    input  logic          adv,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last
);

    localparam logic [CW-1:0] c_ONE  = CW'(1);
    localparam logic [CW:0]   c_ONE1 = (CW+1)'(1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] r_x0;
    logic [CW-1:0] r_x_last;
    logic [CW-1:0] r_y_last;

    // Position and rectangle bounds; reset bounds let the walker start a full-frame sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x0     <= '0;
            r_x_last <= RST_X_LAST;
            r_y_last <= RST_Y_LAST;
        end else if (load) begin
            r_x      <= x0;
            r_y      <= y0;
            r_x0     <= x0;
            r_x_last <= CW'({1'b0, x0} + w - c_ONE1);
            r_y_last <= CW'({1'b0, y0} + h - c_ONE1);
        end else if (adv) begin
            if (r_x == r_x_last) begin
                r_x <= r_x0;
                r_y <= r_y + c_ONE;
            end else begin
                r_x <= r_x + c_ONE;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = (r_x == r_x_last) && (r_y == r_y_last);

endmodule
`default_nettype wire

// File: rtl/rect_fill_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_writer
//  Description : Rectangle-fill write engine for the VGA frame buffer.
//                Accepts one clipped fill command at a time and emits one
//                pixel write per cycle in raster order under valid/ready.
//                Build option RECT_FILL_CLEAR_ON_RESET_EN: after reset the
//                engine first writes colour 0 over the whole active area.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_fill_writer
    import rect_fill_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE_DEF,
    parameter int V_ACTIVE = c_V_ACTIVE_DEF,
    parameter int CW       = 10,
    parameter int RGBW     = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CW-1:0]   cmd_x,
    input  logic [CW-1:0]   cmd_y,
    input  logic [CW-1:0]   cmd_w,
    input  logic [CW-1:0]   cmd_h,
    input  logic [RGBW-1:0] cmd_rgb,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [CW-1:0]   wr_x,
    output logic [CW-1:0]   wr_y,
    output logic [RGBW-1:0] wr_rgb,
    output logic            busy,
    output logic            done
);

    localparam logic [CW:0] c_H = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] c_V = (CW+1)'(V_ACTIVE);

`ifdef RECT_FILL_CLEAR_ON_RESET_EN
    localparam state_t        c_RST_STATE  = ST_CLEAR;
    localparam logic [CW-1:0] c_RST_X_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] c_RST_Y_LAST = CW'(V_ACTIVE - 1);
`else
    localparam state_t        c_RST_STATE  = ST_IDLE;
    localparam logic [CW-1:0] c_RST_X_LAST = '0;
    localparam logic [CW-1:0] c_RST_Y_LAST = '0;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic [RGBW-1:0] r_rgb;
    logic            w_accept;
    logic            w_load;
    logic            w_adv;
    logic            w_last;
    logic [CW:0]     w_room_x;
    logic [CW:0]     w_room_y;
    logic [CW:0]     w_ew;
    logic [CW:0]     w_eh;
    logic            w_empty;

    // Clip the rectangle against the active area in CW+1 bits so nothing wraps
    assign w_room_x = ({1'b0, cmd_x} >= c_H) ? '0 : (c_H - {1'b0, cmd_x});
    assign w_room_y = ({1'b0, cmd_y} >= c_V) ? '0 : (c_V - {1'b0, cmd_y});
    assign w_ew     = ({1'b0, cmd_w} < w_room_x) ? {1'b0, cmd_w} : w_room_x;
    assign w_eh     = ({1'b0, cmd_h} < w_room_y) ? {1'b0, cmd_h} : w_room_y;
    assign w_empty  = (w_ew == '0) || (w_eh == '0);

    // Outputs stay quiet until the first edge after reset release
    assign cmd_ready = r_run && (r_state == ST_IDLE);
    assign wr_valid  = r_run && ((r_state == ST_FILL) || (r_state == ST_CLEAR));
    assign busy      = r_run && (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign wr_rgb    = r_rgb;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_adv     = wr_valid && wr_ready;

    raster_walker #(
        .CW         (CW),
        .RST_X_LAST (c_RST_X_LAST),
        .RST_Y_LAST (c_RST_Y_LAST)
    ) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .x0    (cmd_x),
        .y0    (cmd_y),
        .w     (w_ew),
        .h     (w_eh),
        .adv   (w_adv),
        .x     (wr_x),
        .y     (wr_y),
        .last  (w_last)
    );

    // State register, run flag and latched fill colour (zero for the clear sweep)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RST_STATE;
            r_run   <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_load) begin
                r_rgb <= cmd_rgb;
            end
        end
    end

    // Next-state and walker load decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_empty ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL, ST_CLEAR: begin
                if (w_adv && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill_writer
//  Description : Scoreboard bench for rect_fill_writer. Stimulus pushes the
//                expected pixel writes; a monitor pops and compares them on
//                every write handshake and checks stall stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_fill_writer;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [11:0] cmd_rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [11:0] wr_rgb;
    logic        busy;
    logic        done;

    pix_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rect_fill_writer #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .CW       (10),
        .RGBW     (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_rgb   (cmd_rgb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_rgb    (wr_rgb),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic rdy_pat(input int period, input int k);
        return (period <= 1) ? 1'b1 : ((k % period) == 0);
    endfunction

    task automatic push_rect(input int x0, input int y0, input int ew, input int eh, input logic [11:0] rgb);
        pix_t p;
        for (int yy = 0; yy < eh; yy++) begin
            for (int xx = 0; xx < ew; xx++) begin
                p.x   = 10'(x0 + xx);
                p.y   = 10'(y0 + yy);
                p.rgb = rgb;
                q.push_back(p);
            end
        end
    endtask

    // Issue one command, drive the ready pattern, and check done timing
    task automatic run_cmd(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                           input logic [9:0] h, input logic [11:0] rgb, input int period,
                           input int exp_cycles, input string name);
        int cycles;
        bit rdy_seen;
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_rgb   = rgb;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x     = 10'h155;
        cmd_y     = 10'h0AA;
        cmd_rgb   = 12'h999;
        cycles    = 0;
        rdy_seen  = 1'b0;
        wr_ready  = rdy_pat(period, 0);
        while (!done && cycles < 2000) begin
            if (cmd_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
            wr_ready = rdy_pat(period, cycles);
        end
        chk(done === 1'b1, {name, "_done_seen"}, 64'(done), 64'd1);
        chk(cycles == exp_cycles, {name, "_done_cycle"}, 64'(cycles), 64'(exp_cycles));
        chk(q.size() == 0, {name, "_writes_left"}, 64'(q.size()), 64'd0);
        chk(!rdy_seen, {name, "_ready_while_busy"}, 64'(rdy_seen), 64'd0);
        @(posedge clk);
        #1;
        chk({done, cmd_ready, busy} == 3'b010, {name, "_after_done"}, 64'({done, cmd_ready, busy}), 64'b010);
        wr_ready = 1'b1;
    endtask

    // Monitor: compare each handshaken write and hold stability during stalls
    initial begin
        pix_t        e;
        bit          stalled;
        logic [31:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stalled && wr_valid)
                    chk({wr_x, wr_y, wr_rgb} == held, "stall_hold", 64'({wr_x, wr_y, wr_rgb}), 64'(held));
                if (wr_valid && wr_ready) begin
                    chk(q.size() != 0, "write_expected", 64'(q.size()), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk({wr_x, wr_y, wr_rgb} == {e.x, e.y, e.rgb}, "pixel",
                            64'({wr_x, wr_y, wr_rgb}), 64'({e.x, e.y, e.rgb}));
                    end
                end
                stalled = wr_valid && !wr_ready;
                held    = {wr_x, wr_y, wr_rgb};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_rgb   = '0;
        wr_ready  = 1'b1;
        #1;
        chk({cmd_ready, wr_valid, done, busy} == 4'b0, "reset_ctrl", 64'({cmd_ready, wr_valid, done, busy}), 64'd0);
        chk({wr_x, wr_y, wr_rgb} == 32'd0, "reset_data", 64'({wr_x, wr_y, wr_rgb}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk(cmd_ready == 1'b0, "ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk(cmd_ready == 1'b1, "ready_after_release", 64'(cmd_ready), 64'd1);

        push_rect(10, 20, 3, 2, 12'hF00);
        run_cmd(10'd10, 10'd20, 10'd3, 10'd2, 12'hF00, 1, 6, "basic");

        push_rect(10, 20, 3, 2, 12'hF00);
        run_cmd(10'd10, 10'd20, 10'd3, 10'd2, 12'hF00, 3, 16, "stall3");

        push_rect(100, 200, 2, 3, 12'h5C3);
        run_cmd(10'd100, 10'd200, 10'd2, 10'd3, 12'h5C3, 2, 11, "stall2");

        push_rect(638, 479, 2, 1, 12'h0A5);
        run_cmd(10'd638, 10'd479, 10'd5, 10'd4, 12'h0A5, 1, 2, "clip_xy");

        push_rect(0, 478, 2, 2, 12'h0F0);
        run_cmd(10'd0, 10'd478, 10'd2, 10'd9, 12'h0F0, 1, 4, "clip_y");

        run_cmd(10'd700, 10'd0, 10'd4, 10'd4, 12'h777, 1, 0, "off_right");
        run_cmd(10'd5, 10'd5, 10'd0, 10'd7, 12'hABC, 1, 0, "zero_w");

        // Reset in the middle of a large fill after exactly 37 writes
        push_rect(0, 0, 37, 1, 12'h123);
        cmd_x     = 10'd0;
        cmd_y     = 10'd0;
        cmd_w     = 10'd100;
        cmd_h     = 10'd100;
        cmd_rgb   = 12'h123;
        cmd_valid = 1'b1;
        wr_ready  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(wr_valid == 1'b0, "midrst_wr_valid", 64'(wr_valid), 64'd0);
        chk({done, busy, cmd_ready} == 3'b0, "midrst_ctrl", 64'({done, busy, cmd_ready}), 64'd0);
        chk(q.size() == 0, "midrst_37_writes", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk(done == 1'b0, "midrst_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        chk(cmd_ready == 1'b0, "midrst_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk({cmd_ready, wr_valid, done} == 3'b100, "midrst_idle", 64'({cmd_ready, wr_valid, done}), 64'b100);

        push_rect(1, 2, 2, 1, 12'h00F);
        run_cmd(10'd1, 10'd2, 10'd2, 10'd1, 12'h00F, 1, 2, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
